timer_tick_master: RTL and testbench



---
 rtl/timer_regs_pkg.sv | 17 +
 rtl/timer_tick_master_avm.sv | 33 +++
 rtl/timer_tick_master.sv | 125 ++++++++++++
 tb/tb_timer_tick_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_regs_pkg.sv
// timer_regs_pkg: interval-timer register map, control bit positions and master FSM states
package timer_regs_pkg;
  localparam logic [2:0] STATUS  = 3'd0;
  localparam logic [2:0] CONTROL = 3'd1;
  localparam logic [2:0] PERIODL = 3'd2;
  localparam logic [2:0] PERIODH = 3'd3;
  localparam logic [2:0] SNAPL   = 3'd4;
  localparam logic [2:0] SNAPH   = 3'd5;
  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;
  typedef enum logic [3:0] {
    IDLE, W_STOP, W_PL, W_PH, W_CTRL, RUN, P_RD, P_CAP, W_CLR,
    S_WR, S_RDL, S_CAPL, S_RDH, S_CAPH, W_HALT
  } state_t;
endpackage

// File: rtl/timer_tick_master_avm.sv
// avm_single_access: registers one Avalon-MM read or write per request cycle; done marks the readdata cycle
module avm_single_access (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rd_data,
  output logic        done,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      done           <= 1'b0;
    end else begin
      avm_chipselect <= req;
      avm_write_n    <= !(req && wr);
      avm_address    <= req ? addr : '0;
      avm_writedata  <= (req && wr) ? wdata : '0;
      done           <= avm_chipselect;
    end
  end
  assign rd_data = avm_readdata;
endmodule

// File: rtl/timer_tick_master.sv
// timer_tick_master: Avalon-MM initiator that runs the interval timer, emits sample ticks and snapshots the counter
module timer_tick_master
  import timer_regs_pkg::*;
#(
  parameter int          TICK_CNT_W = 16,
  parameter int          USE_IRQ    = 1,
  parameter logic [15:0] CTRL_RUN   = 16'((1 << ITO) | (1 << CONT) | (1 << START)),
  parameter logic [15:0] CTRL_STOP  = 16'(1 << STOP)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [2:0]            avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write_n,
  output logic [15:0]           avm_writedata,
  input  logic [15:0]           avm_readdata,
  input  logic                  timer_irq,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic                  snap_req,
  output logic                  busy,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic                  cfg_err
);
  state_t      st, nxt;
  logic [31:0] period;
  logic [15:0] snap_lo, rd_data, acc_data;
  logic        stop_pend, done, acc_req, acc_wr;
  logic [2:0]  acc_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = (cfg_start && cfg_period != '0) ? W_STOP : IDLE;
      W_STOP:  nxt = W_PL;
      W_PL:    nxt = W_PH;
      W_PH:    nxt = W_CTRL;
      W_CTRL:  nxt = RUN;
      RUN:     nxt = (cfg_stop || stop_pend)       ? W_HALT :
                     (USE_IRQ != 0 && timer_irq)   ? W_CLR  :
                     snap_req                      ? S_WR   :
                     (USE_IRQ == 0)                ? P_RD   : RUN;
      P_RD:    nxt = P_CAP;
      P_CAP:   nxt = (done && rd_data[0]) ? W_CLR : RUN;
      W_CLR:   nxt = RUN;
      S_WR:    nxt = S_RDL;
      S_RDL:   nxt = S_CAPL;
      S_CAPL:  nxt = S_RDH;
      S_RDH:   nxt = S_CAPH;
      S_CAPH:  nxt = RUN;
      W_HALT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // bus request follows the state being entered so the access lines up with that state's cycle
  always_comb begin
    acc_req  = 1'b0;
    acc_wr   = 1'b0;
    acc_addr = STATUS;
    acc_data = '0;
    case (nxt)
      W_STOP, W_HALT: begin acc_req = 1'b1; acc_wr = 1'b1; acc_addr = CONTROL; acc_data = CTRL_STOP; end
      W_PL:    begin acc_req = 1'b1; acc_wr = 1'b1; acc_addr = PERIODL; acc_data = period[15:0]; end
      W_PH:    begin acc_req = 1'b1; acc_wr = 1'b1; acc_addr = PERIODH; acc_data = period[31:16]; end
      W_CTRL:  begin acc_req = 1'b1; acc_wr = 1'b1; acc_addr = CONTROL; acc_data = CTRL_RUN; end
      W_CLR:   begin acc_req = 1'b1; acc_wr = 1'b1; end
      S_WR:    begin acc_req = 1'b1; acc_wr = 1'b1; acc_addr = SNAPL; end
      P_RD:    acc_req = 1'b1;
      S_RDL:   begin acc_req = 1'b1; acc_addr = SNAPL; end
      S_RDH:   begin acc_req = 1'b1; acc_addr = SNAPH; end
      default: ;
    endcase
  end

  avm_single_access u_acc (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (acc_req),
    .wr             (acc_wr),
    .addr           (acc_addr),
    .wdata          (acc_data),
    .rd_data        (rd_data),
    .done           (done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata)
  );

  // a stop arriving mid-sequence is remembered and acted on at the next RUN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period     <= '0;
      stop_pend  <= 1'b0;
      tick       <= 1'b0;
      tick_count <= '0;
      snap_lo    <= '0;
      snap_valid <= 1'b0;
      snap_value <= '0;
      cfg_err    <= 1'b0;
    end else begin
      if (st == IDLE && cfg_start && cfg_period != '0) period <= cfg_period;
      stop_pend  <= (st == IDLE || st == W_HALT) ? 1'b0 : (stop_pend | cfg_stop);
      tick       <= st == W_CLR;
      if (st == W_CLR) tick_count <= tick_count + TICK_CNT_W'(1);
      if (st == S_CAPL) snap_lo <= rd_data;
      if (st == S_CAPH) snap_value <= {rd_data, snap_lo};
      snap_valid <= st == S_CAPH;
      cfg_err    <= st == IDLE && cfg_start && cfg_period == '0;
    end
  end

  assign busy = st != IDLE;
endmodule

// File: tb/tb_timer_tick_master.sv
// tb_timer_tick_master: scoreboard bench with an interval-timer model; inst0 irq-driven, inst1 polling with a 4-bit tick counter
module tb_timer_tick_master;
  typedef enum logic [2:0] {EV_WR, EV_RD, EV_TICK, EV_SNAP, EV_ERR} ev_k;
  typedef struct {
    int          inst;
    ev_k         kind;
    logic [2:0]  addr;
    logic [31:0] data;
    bit          dc;
  } ev_t;

  ev_t sbq[$];
  int  n_chk = 0;
  int  n_err = 0;

  logic        clk, reset_n;
  logic [2:0]  avm_address [2];
  logic        avm_chipselect [2];
  logic        avm_write_n [2];
  logic [15:0] avm_writedata [2];
  logic [15:0] avm_readdata [2];
  logic        timer_irq [2];
  logic [31:0] cfg_period [2];
  logic        cfg_start [2];
  logic        cfg_stop [2];
  logic        snap_req [2];
  logic        busy [2];
  logic        tick [2];
  logic        snap_valid [2];
  logic [31:0] snap_value [2];
  logic        cfg_err [2];
  logic [15:0] tc0;
  logic [3:0]  tc1;

  logic [31:0] t_cnt [2];
  logic [31:0] t_per [2];
  logic [31:0] t_snap [2];
  logic [31:0] ctr_val [2];
  logic        t_run [2];
  logic        t_to [2];

  timer_tick_master #(.USE_IRQ(1)) u_irq (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address[0]), .avm_chipselect(avm_chipselect[0]), .avm_write_n(avm_write_n[0]),
    .avm_writedata(avm_writedata[0]), .avm_readdata(avm_readdata[0]), .timer_irq(timer_irq[0]),
    .cfg_period(cfg_period[0]), .cfg_start(cfg_start[0]), .cfg_stop(cfg_stop[0]), .snap_req(snap_req[0]),
    .busy(busy[0]), .tick(tick[0]), .tick_count(tc0), .snap_valid(snap_valid[0]),
    .snap_value(snap_value[0]), .cfg_err(cfg_err[0])
  );

  timer_tick_master #(.TICK_CNT_W(4), .USE_IRQ(0)) u_poll (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address[1]), .avm_chipselect(avm_chipselect[1]), .avm_write_n(avm_write_n[1]),
    .avm_writedata(avm_writedata[1]), .avm_readdata(avm_readdata[1]), .timer_irq(timer_irq[1]),
    .cfg_period(cfg_period[1]), .cfg_start(cfg_start[1]), .cfg_stop(cfg_stop[1]), .snap_req(snap_req[1]),
    .busy(busy[1]), .tick(tick[1]), .tick_count(tc1), .snap_valid(snap_valid[1]),
    .snap_value(snap_value[1]), .cfg_err(cfg_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // interval timer model: a pending timeout coinciding with a status clear is lost
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        t_cnt[i] <= '0; t_per[i] <= '0; t_snap[i] <= '0; t_run[i] <= 1'b0; t_to[i] <= 1'b0;
        avm_readdata[i] <= '0;
      end else begin
        if (t_run[i]) begin
          if (t_cnt[i] == 0) begin t_to[i] <= 1'b1; t_cnt[i] <= t_per[i]; end
          else t_cnt[i] <= t_cnt[i] - 1;
        end
        avm_readdata[i] <= !(avm_chipselect[i] && avm_write_n[i]) ? 16'h0 :
                           avm_address[i] == 3'd0 ? {15'h0, t_to[i]} :
                           avm_address[i] == 3'd4 ? t_snap[i][15:0] :
                           avm_address[i] == 3'd5 ? t_snap[i][31:16] : 16'h0;
        if (avm_chipselect[i] && !avm_write_n[i]) begin
          case (avm_address[i])
            3'd0: t_to[i] <= 1'b0;
            3'd1: begin
              if (avm_writedata[i][3]) t_run[i] <= 1'b0;
              if (avm_writedata[i][2]) begin t_run[i] <= 1'b1; t_cnt[i] <= t_per[i]; end
            end
            3'd2: t_per[i][15:0]  <= avm_writedata[i];
            3'd3: t_per[i][31:16] <= avm_writedata[i];
            3'd4: t_snap[i] <= ctr_val[i];
            default: ;
          endcase
        end
      end
    end
  end
  assign timer_irq[0] = t_to[0];
  assign timer_irq[1] = t_to[1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input ev_k k, input logic [2:0] a, input logic [31:0] d, input bit dc);
    ev_t e;
    e.inst = i; e.kind = k; e.addr = a; e.data = d; e.dc = dc;
    sbq.push_back(e);
  endtask

  task automatic observe(input int i, input ev_k k, input logic [2:0] a, input logic [31:0] d);
    ev_t e;
    bit  ok;
    n_chk++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected: got inst%0d kind=%0d addr=%0d data=%h, expected nothing", i, k, a, d);
    end else begin
      e  = sbq.pop_front();
      ok = e.inst == i && e.kind == k && ((k != EV_WR && k != EV_RD) || e.addr == a) && (e.dc || e.data == d);
      if (!ok) begin
        n_err++;
        $display("FAIL sb_event: got inst%0d kind=%0d addr=%0d data=%h, expected inst%0d kind=%0d addr=%0d data=%h",
                 i, k, a, d, e.inst, e.kind, e.addr, e.data);
      end
    end
  endtask

  bit prev_srd = 1'b0;
  bit last_to  = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_srd) last_to = avm_readdata[1][0];
      prev_srd = avm_chipselect[1] && avm_write_n[1];
      for (int i = 0; i < 2; i++) begin
        if (avm_chipselect[i] && avm_write_n[i] && i == 1)
          chk("poll_read_addr", {29'h0, avm_address[1]}, 32'h0);
        else if (avm_chipselect[i])
          observe(i, avm_write_n[i] ? EV_RD : EV_WR, avm_address[i], avm_write_n[i] ? 32'h0 : {16'h0, avm_writedata[i]});
        if (i == 1 && avm_chipselect[1] && !avm_write_n[1] && avm_address[1] == 3'd0) begin
          chk("poll_clear_after_to", {31'h0, last_to}, 32'h1);
          last_to = 1'b0;
        end
        if (tick[i]) observe(i, EV_TICK, 3'd0, i == 0 ? {16'h0, tc0} : {28'h0, tc1});
        if (snap_valid[i]) observe(i, EV_SNAP, 3'd0, snap_value[i]);
        if (cfg_err[i]) observe(i, EV_ERR, 3'd0, 32'h0);
      end
    end
  end

  task automatic push_start(input int i, input logic [31:0] p);
    push(i, EV_WR, 3'd1, 32'h0008, 1'b0);
    push(i, EV_WR, 3'd2, {16'h0, p[15:0]}, 1'b0);
    push(i, EV_WR, 3'd3, {16'h0, p[31:16]}, 1'b0);
    push(i, EV_WR, 3'd1, 32'h0007, 1'b0);
  endtask

  task automatic pulse_start(input int i, input logic [31:0] p);
    cfg_period[i] = p;
    cfg_start[i]  = 1'b1;
    @(negedge clk);
    cfg_start[i]  = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int c;
    c = 0;
    while (busy[i] && c < 40) begin @(negedge clk); c++; end
    chk("wait_idle", {31'h0, busy[i]}, 32'h0);
  endtask

  task automatic run_ticks(input int i, input int n, input int budget);
    int nt;
    int c;
    nt = 0;
    c  = 0;
    while (nt < n && c < budget) begin
      @(negedge clk);
      c++;
      if (tick[i]) begin
        nt++;
        if (i == 1 && nt == 4) chk("poll_tick_count_4", {28'h0, tc1}, 32'h4);
      end
    end
    chk("tick_budget", nt, n);
    cfg_stop[i] = 1'b1;
    @(negedge clk);
    cfg_stop[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cfg_period[i] = '0; cfg_start[i] = 1'b0; cfg_stop[i] = 1'b0; snap_req[i] = 1'b0; ctr_val[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_bus", {11'h0, avm_chipselect[0], avm_write_n[0], avm_address[0], avm_writedata[0]}, {11'h0, 1'b0, 1'b1, 3'd0, 16'h0});
    chk("rst_flags", {28'h0, busy[0], tick[0], snap_valid[0], cfg_err[0]}, 32'h0);
    chk("rst_counts", {16'h0, tc0} | snap_value[0], 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    push_start(0, 32'h0000C350);
    chk("busy_before_start", {31'h0, busy[0]}, 32'h0);
    pulse_start(0, 32'h0000C350);
    chk("busy_after_start", {31'h0, busy[0]}, 32'h1);
    chk("start_w1", {11'h0, avm_chipselect[0], avm_write_n[0], avm_address[0], avm_writedata[0]}, {11'h0, 1'b1, 1'b0, 3'd1, 16'h0008});
    @(negedge clk);
    chk("start_w2", {11'h0, avm_chipselect[0], avm_write_n[0], avm_address[0], avm_writedata[0]}, {11'h0, 1'b1, 1'b0, 3'd2, 16'hC350});
    @(negedge clk);
    chk("start_w3", {11'h0, avm_chipselect[0], avm_write_n[0], avm_address[0], avm_writedata[0]}, {11'h0, 1'b1, 1'b0, 3'd3, 16'h0000});
    @(negedge clk);
    chk("start_w4", {11'h0, avm_chipselect[0], avm_write_n[0], avm_address[0], avm_writedata[0]}, {11'h0, 1'b1, 1'b0, 3'd1, 16'h0007});
    @(negedge clk);
    chk("run_bus_idle", {30'h0, avm_chipselect[0], busy[0]}, 32'h1);
    repeat (3) @(negedge clk);

    ctr_val[0] = 32'h0001_2345;
    push(0, EV_WR, 3'd4, 32'h0, 1'b1);
    push(0, EV_RD, 3'd4, 32'h0, 1'b0);
    push(0, EV_RD, 3'd5, 32'h0, 1'b0);
    push(0, EV_SNAP, 3'd0, 32'h0001_2345, 1'b0);
    snap_req[0] = 1'b1;
    @(negedge clk);
    snap_req[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("snap_value", snap_value[0], 32'h0001_2345);

    ctr_val[0] = 32'h00AB_CDEF;
    push(0, EV_WR, 3'd4, 32'h0, 1'b1);
    push(0, EV_RD, 3'd4, 32'h0, 1'b0);
    push(0, EV_RD, 3'd5, 32'h0, 1'b0);
    push(0, EV_SNAP, 3'd0, 32'h00AB_CDEF, 1'b0);
    push(0, EV_WR, 3'd1, 32'h0008, 1'b0);
    snap_req[0] = 1'b1;
    @(negedge clk);
    snap_req[0] = 1'b0;
    @(negedge clk);
    cfg_stop[0] = 1'b1;
    @(negedge clk);
    cfg_stop[0] = 1'b0;
    wait_idle(0);

    push(0, EV_ERR, 3'd0, 32'h0, 1'b0);
    pulse_start(0, 32'h0);
    chk("cfg_err_pulse", {31'h0, cfg_err[0]}, 32'h1);
    chk("cfg_err_stays_idle", {31'h0, busy[0]}, 32'h0);
    repeat (4) @(negedge clk);

    push_start(0, 32'd9);
    for (int k = 1; k <= 4; k++) begin
      push(0, EV_WR, 3'd0, 32'h0, 1'b0);
      push(0, EV_TICK, 3'd0, k, 1'b0);
    end
    push(0, EV_WR, 3'd1, 32'h0008, 1'b0);
    pulse_start(0, 32'd9);
    run_ticks(0, 4, 300);
    chk("irq_tick_count", {16'h0, tc0}, 32'h4);
    wait_idle(0);

    push_start(1, 32'd9);
    for (int k = 1; k <= 16; k++) begin
      push(1, EV_WR, 3'd0, 32'h0, 1'b0);
      push(1, EV_TICK, 3'd0, k % 16, 1'b0);
    end
    push(1, EV_WR, 3'd1, 32'h0008, 1'b0);
    pulse_start(1, 32'd9);
    run_ticks(1, 16, 800);
    chk("poll_tick_wrap", {28'h0, tc1}, 32'h0);
    wait_idle(1);

    push(0, EV_WR, 3'd1, 32'h0008, 1'b0);
    push(0, EV_WR, 3'd2, 32'h0010, 1'b0);
    push(0, EV_WR, 3'd3, 32'h0005, 1'b0);
    pulse_start(0, 32'h0005_0010);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_bus", {11'h0, avm_chipselect[0], avm_write_n[0], avm_address[0], avm_writedata[0]}, {11'h0, 1'b0, 1'b1, 3'd0, 16'h0});
    chk("mid_rst_flags", {28'h0, busy[0], tick[0], snap_valid[0], cfg_err[0]}, 32'h0);
    chk("mid_rst_tick_count", {16'h0, tc0}, 32'h0);
    chk("mid_rst_snap_value", snap_value[0], 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
